// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO for MIDI byte/event buffering with fill count, programmable
// almost flags, sticky overflow/underflow and optional first-word-fall-through.
module fifo_sync_flags #(
    parameter int WIDTH         = 8,
    parameter int ADDR_SIZE     = 9,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = (1 << ADDR_SIZE) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 clr_err,
    input  logic                 wr,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 rd,
    output logic [WIDTH-1:0]     data_o,
    output logic                 empty_n,
    output logic                 full_n,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    typedef logic [ADDR_SIZE:0] cnt_t;
    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AF_C    = cnt_t'(AFULL_THRESH);
    localparam cnt_t AE_C    = cnt_t'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    cnt_t             wr_ptr, rd_ptr, count_nxt;
    logic             wr_ok, rd_ok, ov_evt, uf_evt;

    // flush wins over both requests; dropped requests are not errors
    assign wr_ok  = wr & full_n  & ~flush;
    assign rd_ok  = rd & empty_n & ~flush;
    assign ov_evt = wr & ~full_n  & ~flush;
    assign uf_evt = rd & ~empty_n & ~flush;

    assign count_nxt = flush ? '0 : count + cnt_t'(wr_ok) - cnt_t'(rd_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty_n      <= 1'b0;
            full_n       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + cnt_t'(1);
                if (rd_ok) rd_ptr <= rd_ptr + cnt_t'(1);
            end
            count        <= count_nxt;
            empty_n      <= (count_nxt != '0);
            full_n       <= (count_nxt != DEPTH_C);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            // a fresh error in the clearing cycle keeps the flag set
            overflow     <= (overflow  & ~clr_err) | ov_evt;
            underflow    <= (underflow & ~clr_err) | uf_evt;
        end
    end

    // storage is deliberately never cleared
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[ADDR_SIZE-1:0]] <= data_i;
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_o = mem[rd_ptr[ADDR_SIZE-1:0]];
        end else begin : g_std
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)   data_o <= '0;
                else if (rd_ok) data_o <= mem[rd_ptr[ADDR_SIZE-1:0]];
            end
        end
    endgenerate
endmodule
